iob2axil_bridge: RTL and testbench

IOB2AXIL_BRIDGE -- requirements
Module: iob2axil_bridge

---
 rtl/iob2axil_bridge_if.sv | 68 ++++++
 rtl/iob2axil_bridge.sv | 179 +++++++++++++++++
 tb/tb_iob2axil_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob2axil_bridge_if.sv
// IOb request/response channel and AXI4-Lite master channels of the iob2axil bridge.
// master = bridge view, slave = requester plus AXI4-Lite target view.
interface iob2axil_bridge_if #(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
);
  logic                     iob_valid_i;
  logic [ADDR_W-1:0]        iob_addr_i;
  logic [DATA_W-1:0]        iob_wdata_i;
  logic [DATA_W/8-1:0]      iob_wstrb_i;
  logic                     iob_ready_o;
  logic                     iob_rvalid_o;
  logic [DATA_W-1:0]        iob_rdata_o;
  logic                     iob_wack_o;
  logic                     iob_err_o;

  logic                     axil_awvalid_o;
  logic                     axil_awready_i;
  logic [AXIL_ADDR_W-1:0]   axil_awaddr_o;
  logic [2:0]               axil_awprot_o;
  logic                     axil_wvalid_o;
  logic                     axil_wready_i;
  logic [AXIL_DATA_W-1:0]   axil_wdata_o;
  logic [AXIL_DATA_W/8-1:0] axil_wstrb_o;
  logic                     axil_bvalid_i;
  logic                     axil_bready_o;
  logic [1:0]               axil_bresp_i;
  logic                     axil_arvalid_o;
  logic                     axil_arready_i;
  logic [AXIL_ADDR_W-1:0]   axil_araddr_o;
  logic [2:0]               axil_arprot_o;
  logic                     axil_rvalid_i;
  logic                     axil_rready_o;
  logic [AXIL_DATA_W-1:0]   axil_rdata_i;
  logic [1:0]               axil_rresp_i;

  modport master (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rvalid_o, iob_rdata_o, iob_wack_o, iob_err_o,
    output axil_awvalid_o, axil_awaddr_o, axil_awprot_o,
    input  axil_awready_i,
    output axil_wvalid_o, axil_wdata_o, axil_wstrb_o,
    input  axil_wready_i,
    input  axil_bvalid_i, axil_bresp_i,
    output axil_bready_o,
    output axil_arvalid_o, axil_araddr_o, axil_arprot_o,
    input  axil_arready_i,
    input  axil_rvalid_i, axil_rdata_i, axil_rresp_i,
    output axil_rready_o
  );

  modport slave (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rvalid_o, iob_rdata_o, iob_wack_o, iob_err_o,
    input  axil_awvalid_o, axil_awaddr_o, axil_awprot_o,
    output axil_awready_i,
    input  axil_wvalid_o, axil_wdata_o, axil_wstrb_o,
    output axil_wready_i,
    output axil_bvalid_i, axil_bresp_i,
    input  axil_bready_o,
    input  axil_arvalid_o, axil_araddr_o, axil_arprot_o,
    output axil_arready_i,
    output axil_rvalid_i, axil_rdata_i, axil_rresp_i,
    input  axil_rready_o
  );
endinterface

// File: rtl/iob2axil_bridge.sv
// IOb slave to AXI4-Lite master bridge, one transaction outstanding, optional response timeout.
// Completion pulses are combinational from B/R so write and read complete 2 cycles after accept.
module iob2axil_bridge #(
  parameter int         AXIL_ADDR_W = 21,
  parameter int         AXIL_DATA_W = 32,
  parameter int         ADDR_W      = AXIL_ADDR_W,
  parameter int         DATA_W      = AXIL_DATA_W,
  parameter logic [2:0] PROT        = 3'd2,
  parameter int         TIMEOUT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  iob2axil_bridge_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t             state;
  logic               ready_q;
  logic               awvalid_q;
  logic               wvalid_q;
  logic               bready_q;
  logic               arvalid_q;
  logic               rready_q;
  logic               aw_done;
  logic               w_done;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic [CNT_W-1:0]   cnt;

  logic accept;
  logic is_wr;
  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic r_fire;
  logic tmo;

  assign accept  = bus.iob_valid_i & bus.iob_ready_o;
  assign is_wr   = |bus.iob_wstrb_i;
  assign aw_fire = awvalid_q & bus.axil_awready_i;
  assign w_fire  = wvalid_q & bus.axil_wready_i;
  assign b_fire  = bready_q & bus.axil_bvalid_i;
  assign r_fire  = rready_q & bus.axil_rvalid_i;

  // The counter only advances while a response is awaited, so it can never abort a pending AW/W/AR.
  generate
    if (TIMEOUT_W > 0) begin : g_tmo
      assign tmo = (bready_q | rready_q) & (&cnt);
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.iob_addr_i;
            wdata_q <= bus.iob_wdata_i;
            wstrb_q <= bus.iob_wstrb_i;
            ready_q <= 1'b0;
            if (is_wr) begin
              state     <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        WR: begin
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done | aw_fire) & (w_done | w_fire)) begin
            state    <= WRESP;
            bready_q <= 1'b1;
            cnt      <= '0;
          end
        end

        WRESP: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.axil_bvalid_i | tmo) begin
            state    <= IDLE;
            bready_q <= 1'b0;
            ready_q  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end

        RADDR: begin
          if (bus.axil_arready_i) begin
            state     <= RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt       <= '0;
          end
        end

        RDATA: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.axil_rvalid_i | tmo) begin
            state    <= IDLE;
            rready_q <= 1'b0;
            ready_q  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          ready_q   <= 1'b1;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iob_ready_o    = ready_q & rst_n_i;
  assign bus.axil_awvalid_o = awvalid_q;
  assign bus.axil_awaddr_o  = AXIL_ADDR_W'(addr_q);
  assign bus.axil_awprot_o  = PROT;
  assign bus.axil_wvalid_o  = wvalid_q;
  assign bus.axil_wdata_o   = AXIL_DATA_W'(wdata_q);
  assign bus.axil_wstrb_o   = wstrb_q;
  assign bus.axil_bready_o  = bready_q;
  assign bus.axil_arvalid_o = arvalid_q;
  assign bus.axil_araddr_o  = AXIL_ADDR_W'(addr_q);
  assign bus.axil_arprot_o  = PROT;
  assign bus.axil_rready_o  = rready_q;

  // Reset gates the completion outputs so an aborted transaction never reports back.
  assign bus.iob_wack_o   = rst_n_i & bready_q & (bus.axil_bvalid_i | tmo);
  assign bus.iob_rvalid_o = rst_n_i & rready_q & (bus.axil_rvalid_i | tmo);
  assign bus.iob_err_o    = rst_n_i & ((bready_q & (bus.axil_bvalid_i ? (|bus.axil_bresp_i) : tmo)) |
                                       (rready_q & (bus.axil_rvalid_i ? (|bus.axil_rresp_i) : tmo)));
  assign bus.iob_rdata_o  = (rst_n_i & r_fire) ? DATA_W'(bus.axil_rdata_i) : '0;

endmodule

// File: tb/tb_iob2axil_bridge.sv
// Bench for iob2axil_bridge: vector table of single transactions against a delay-programmable AXI4-Lite target,
// completions checked through an expectation queue, plus reset-abort and back-to-back sequences.
module tb_iob2axil_bridge;
  localparam int AW    = 21;
  localparam int DW    = 32;
  localparam int NEVER = 255;
  localparam int NV    = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iob2axil_bridge_if #(.AXIL_ADDR_W(AW), .AXIL_DATA_W(DW)) bus ();

  iob2axil_bridge #(
    .AXIL_ADDR_W(AW), .AXIL_DATA_W(DW), .PROT(3'd2), .TIMEOUT_W(4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI4-Lite target model with per-channel ready/response delays
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  logic        slv_clr = 1'b0;

  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic aw_got, w_got, ar_got;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [AW-1:0] aw_addr_log, ar_addr_log;
  logic [31:0]   w_data_log;
  logic [3:0]    w_strb_log;
  logic [2:0]    awprot_log, arprot_log;

  always @(posedge clk) begin
    if (!rst_n || slv_clr) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_got  <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
    end else begin
      if (bus.axil_awvalid_o) begin
        if (bus.axil_awready_i) begin
          aw_wait <= 0; aw_got <= 1'b1; aw_hs <= aw_hs + 1;
          aw_addr_log <= bus.axil_awaddr_o; awprot_log <= bus.axil_awprot_o;
        end else aw_wait <= aw_wait + 1;
      end
      if (bus.axil_wvalid_o) begin
        if (bus.axil_wready_i) begin
          w_wait <= 0; w_got <= 1'b1; w_hs <= w_hs + 1;
          w_data_log <= bus.axil_wdata_o; w_strb_log <= bus.axil_wstrb_o;
        end else w_wait <= w_wait + 1;
      end
      if (aw_got && w_got) begin
        if (bus.axil_bvalid_i && bus.axil_bready_o) begin
          aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
        end else if (!bus.axil_bvalid_i) b_wait <= b_wait + 1;
      end
      if (bus.axil_arvalid_o) begin
        if (bus.axil_arready_i) begin
          ar_wait <= 0; ar_got <= 1'b1; ar_hs <= ar_hs + 1;
          ar_addr_log <= bus.axil_araddr_o; arprot_log <= bus.axil_arprot_o;
        end else ar_wait <= ar_wait + 1;
      end
      if (ar_got) begin
        if (bus.axil_rvalid_i && bus.axil_rready_o) begin
          ar_got <= 1'b0; r_wait <= 0;
        end else if (!bus.axil_rvalid_i) r_wait <= r_wait + 1;
      end
    end
  end

  always @(negedge clk) begin
    bus.axil_awready_i = bus.axil_awvalid_o && (aw_wait >= aw_dly);
    bus.axil_wready_i  = bus.axil_wvalid_o && (w_wait >= w_dly);
    bus.axil_bvalid_i  = aw_got && w_got && (b_dly != NEVER) && (b_wait >= b_dly);
    bus.axil_bresp_i   = bresp_cfg;
    bus.axil_arready_i = bus.axil_arvalid_o && (ar_wait >= ar_dly);
    bus.axil_rvalid_i  = ar_got && (r_dly != NEVER) && (r_wait >= r_dly);
    bus.axil_rresp_i   = rresp_cfg;
    bus.axil_rdata_i   = rdata_cfg;
  end

  // Completion scoreboard
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int comp_cnt = 0;
  int comp_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.iob_wack_o || bus.iob_rvalid_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_completion: got wack=%0b rvalid=%0b at cycle %0d expected none",
                 bus.iob_wack_o, bus.iob_rvalid_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("comp_kind", {bus.iob_wack_o, bus.iob_rvalid_o}, e.wr ? 2'b10 : 2'b01);
        check("comp_err", bus.iob_err_o, e.err);
        if (!e.wr) check("comp_rdata", bus.iob_rdata_o, e.rdata);
      end
      comp_cnt++;
      comp_cyc = cyc;
    end
  end

  // AXI protocol monitor: channel exclusivity and valid/payload stability until handshake
  int viol = 0;
  logic h_aw = 1'b0, h_w = 1'b0, h_ar = 1'b0;
  logic [AW-1:0] h_awaddr, h_araddr;
  logic [31:0]   h_wdata;
  logic [3:0]    h_wstrb;
  always @(posedge clk) begin
    int v;
    v = 0;
    if (rst_n) begin
      if ((bus.axil_awvalid_o || bus.axil_wvalid_o) && bus.axil_arvalid_o) v++;
      if (bus.iob_ready_o && (bus.axil_awvalid_o || bus.axil_wvalid_o || bus.axil_arvalid_o ||
                              bus.axil_bready_o || bus.axil_rready_o)) v++;
      if (bus.axil_bready_o && bus.axil_rready_o) v++;
      if (h_aw && (!bus.axil_awvalid_o || bus.axil_awaddr_o != h_awaddr)) v++;
      if (h_w && (!bus.axil_wvalid_o || bus.axil_wdata_o != h_wdata || bus.axil_wstrb_o != h_wstrb)) v++;
      if (h_ar && (!bus.axil_arvalid_o || bus.axil_araddr_o != h_araddr)) v++;
    end
    viol     <= viol + v;
    h_aw     <= rst_n && bus.axil_awvalid_o && !bus.axil_awready_i;
    h_w      <= rst_n && bus.axil_wvalid_o && !bus.axil_wready_i;
    h_ar     <= rst_n && bus.axil_arvalid_o && !bus.axil_arready_i;
    h_awaddr <= bus.axil_awaddr_o;
    h_araddr <= bus.axil_araddr_o;
    h_wdata  <= bus.axil_wdata_o;
    h_wstrb  <= bus.axil_wstrb_o;
  end

  typedef struct {
    bit          wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vt[NV];

  task automatic slave_setup(input int a, input int w, input int b, input int ar, input int r,
                             input logic [1:0] resp, input logic [31:0] rd);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    bresp_cfg = resp; rresp_cfg = resp; rdata_cfg = rd;
    slv_clr = 1'b1;
    @(posedge clk);
    #1 slv_clr = 1'b0;
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int acc_cyc, c0, aw0, w0, ar0;
    bit got;
    exp_t e;
    slave_setup(v.aw_dly, v.w_dly, v.b_dly, v.ar_dly, v.r_dly, v.resp, v.rdata);
    @(negedge clk);
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; c0 = comp_cnt;
    bus.iob_valid_i = 1'b1;
    bus.iob_addr_i  = v.addr;
    bus.iob_wdata_i = v.wdata;
    bus.iob_wstrb_i = v.wr ? v.wstrb : 4'h0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #2;
      if (bus.iob_ready_o) got = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("v%0d_accept", idx), got, 1);
    acc_cyc = cyc;
    e.wr = v.wr; e.rdata = v.exp_rdata; e.err = v.exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble the request so any AXI output following the IOb inputs shows up
    bus.iob_valid_i = 1'b0;
    bus.iob_addr_i  = ~v.addr;
    bus.iob_wdata_i = ~v.wdata;
    bus.iob_wstrb_i = 4'h0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      #3;
      if (comp_cnt != c0) got = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("v%0d_done", idx), got, 1);
    if (!got) exp_q.delete();
    check($sformatf("v%0d_latency", idx), comp_cyc - acc_cyc, v.exp_lat);
    check($sformatf("v%0d_aw_hs", idx), aw_hs - aw0, v.wr ? 1 : 0);
    check($sformatf("v%0d_w_hs", idx), w_hs - w0, v.wr ? 1 : 0);
    check($sformatf("v%0d_ar_hs", idx), ar_hs - ar0, v.wr ? 0 : 1);
    if (v.wr) begin
      check($sformatf("v%0d_awaddr", idx), aw_addr_log, v.addr);
      check($sformatf("v%0d_wdata", idx), w_data_log, v.wdata);
      check($sformatf("v%0d_wstrb", idx), w_strb_log, v.wstrb);
      check($sformatf("v%0d_awprot", idx), awprot_log, 3'd2);
    end else begin
      check($sformatf("v%0d_araddr", idx), ar_addr_log, v.addr);
      check($sformatf("v%0d_arprot", idx), arprot_log, 3'd2);
    end
    @(negedge clk);
    #2;
    check($sformatf("v%0d_idle_after", idx),
          {bus.iob_ready_o, bus.axil_bready_o, bus.axil_rready_o,
           bus.axil_awvalid_o, bus.axil_wvalid_o, bus.axil_arvalid_o}, 6'b100000);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, acc1, acc2;
    bit got;
    exp_t e;

    //            wr addr        wdata         strb  aw w  b      ar r      resp   rdata         err rdata_exp     lat
    vt[0]  = '{1, 21'h00010,  32'hDEADBEEF, 4'hF, 0, 0, 0,     0, 0,     2'b00, 32'h0,        0, 32'h0,        2};
    vt[1]  = '{0, 21'h00020,  32'h0,        4'h0, 0, 0, 0,     2, 0,     2'b10, 32'h12345678, 1, 32'h12345678, 4};
    vt[2]  = '{1, 21'h1FFFFC, 32'hA5A5A5A5, 4'h3, 0, 3, 0,     0, 0,     2'b00, 32'h0,        0, 32'h0,        5};
    vt[3]  = '{1, 21'h00044,  32'h01020304, 4'hC, 2, 0, 0,     0, 0,     2'b11, 32'h0,        1, 32'h0,        4};
    vt[4]  = '{1, 21'h00048,  32'hCAFEF00D, 4'h1, 0, 0, 3,     0, 0,     2'b01, 32'h0,        1, 32'h0,        5};
    vt[5]  = '{0, 21'h00000,  32'h0,        4'h0, 0, 0, 0,     0, 0,     2'b00, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2};
    vt[6]  = '{0, 21'h1ABCD4, 32'h0,        4'h0, 0, 0, 0,     0, 5,     2'b01, 32'h0BADF00D, 1, 32'h0BADF00D, 7};
    vt[7]  = '{1, 21'h00008,  32'h11223344, 4'h8, 0, 0, 14,    0, 0,     2'b00, 32'h0,        0, 32'h0,        16};
    vt[8]  = '{0, 21'h00030,  32'h0,        4'h0, 0, 0, 0,     0, NEVER, 2'b00, 32'h55AA55AA, 1, 32'h0,        17};
    vt[9]  = '{1, 21'h00034,  32'h66778899, 4'hF, 0, 0, NEVER, 0, 0,     2'b00, 32'h0,        1, 32'h0,        17};
    vt[10] = '{0, 21'h0003C,  32'h0,        4'h0, 0, 0, 0,     1, 14,    2'b00, 32'h87654321, 0, 32'h87654321, 17};

    bus.iob_valid_i = 1'b0;
    bus.iob_addr_i  = '0;
    bus.iob_wdata_i = '0;
    bus.iob_wstrb_i = '0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = 32'h0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_outputs",
          {bus.iob_ready_o, bus.axil_awvalid_o, bus.axil_wvalid_o, bus.axil_arvalid_o,
           bus.axil_bready_o, bus.axil_rready_o, bus.iob_wack_o, bus.iob_rvalid_o, bus.iob_err_o}, 9'b0);
    check("rst_rdata", bus.iob_rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_release_ready", bus.iob_ready_o, 1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) do_txn(vt[i], i);

    // Reset while the write is stuck in the address/data phase
    slave_setup(10, 10, 0, 0, 0, 2'b00, 32'h0);
    @(negedge clk);
    c0 = comp_cnt;
    bus.iob_valid_i = 1'b1; bus.iob_addr_i = 21'h00060; bus.iob_wdata_i = 32'h0F0F0F0F; bus.iob_wstrb_i = 4'hF;
    #2;
    check("rstwr_accept_ready", bus.iob_ready_o, 1);
    @(negedge clk);
    bus.iob_valid_i = 1'b0; bus.iob_wstrb_i = 4'h0;
    @(negedge clk);
    #2;
    check("rstwr_in_wr", {bus.axil_awvalid_o, bus.axil_wvalid_o}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check("rstwr_valids_cleared", {bus.axil_awvalid_o, bus.axil_wvalid_o, bus.axil_arvalid_o,
                                   bus.axil_bready_o, bus.axil_rready_o}, 5'b0);
    check("rstwr_ready_in_reset", bus.iob_ready_o, 0);
    rst_n = 1'b1;
    #1;
    check("rstwr_ready_after", bus.iob_ready_o, 1);
    repeat (6) @(negedge clk);
    check("rstwr_no_wack", comp_cnt - c0, 0);

    // Back-to-back with iob_valid held: write then read
    slave_setup(0, 0, 0, 0, 0, 2'b00, 32'h13579BDF);
    @(negedge clk);
    c0 = comp_cnt;
    bus.iob_valid_i = 1'b1; bus.iob_addr_i = 21'h00040; bus.iob_wdata_i = 32'hFEEDFACE; bus.iob_wstrb_i = 4'hF;
    #2;
    check("b2b_first_ready", bus.iob_ready_o, 1);
    acc1 = cyc;
    e.wr = 1'b1; e.rdata = 32'h0; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.iob_addr_i = 21'h00050; bus.iob_wstrb_i = 4'h0;
    e.wr = 1'b0; e.rdata = 32'h13579BDF; e.err = 1'b0;
    exp_q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #2;
      if (bus.iob_ready_o) got = 1'b1;
      else @(negedge clk);
    end
    acc2 = cyc;
    check("b2b_second_accept", got, 1);
    check("b2b_first_latency", comp_cyc - acc1, 2);
    check("b2b_gap_after_completion", acc2 - comp_cyc, 1);
    @(negedge clk);
    bus.iob_valid_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #3;
      if (comp_cnt - c0 >= 2) got = 1'b1;
      else @(negedge clk);
    end
    check("b2b_both_done", got, 1);
    check("b2b_second_latency", comp_cyc - acc2, 2);
    check("b2b_araddr", ar_addr_log, 21'h00050);
    if (!got) exp_q.delete();
    repeat (3) @(negedge clk);

    check("axi_protocol_violations", viol, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
